// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I byte-addressed load/store front end for a word-addressed,
//            one-cycle-latency data memory; sub-word stores via read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module load_store_unit #(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_CAP   = 3'd2,
        S_MERGE = 3'd3,
        S_WR    = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic          r_we;
    logic [2:0]    r_funct3;
    logic [1:0]    r_lane;
    logic [AW-1:0] r_widx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_resp_data;
    logic          r_resp_err;

    logic          w_accept;
    logic          w_f3_legal;
    logic          w_misalign;
    logic          w_out_of_range;
    logic          w_err;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_merged;

    assign w_accept = req_valid && req_ready;

    assign w_f3_legal = req_we
        ? (req_funct3 == c_F3_B || req_funct3 == c_F3_H || req_funct3 == c_F3_W)
        : (req_funct3 == c_F3_B || req_funct3 == c_F3_H || req_funct3 == c_F3_W ||
           req_funct3 == c_F3_BU || req_funct3 == c_F3_HU);

    // funct3[1:0] encodes access size for every legal code (00 B, 01 H, 10 W)
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_out_of_range = |req_addr[31:AW+2];
    assign w_err = !w_f3_legal || w_misalign || w_out_of_range;

    assign w_byte = mem_read_data[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    always_comb begin
        w_load_data = mem_read_data;
        case (r_funct3)
            c_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: w_load_data = {24'd0, w_byte};
            c_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_HU: w_load_data = {16'd0, w_half};
            default: w_load_data = mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = mem_read_data;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)
                        w_state_next = S_RESP;
                    else if (req_we && (req_funct3 == c_F3_W))
                        w_state_next = S_WR;
                    else
                        w_state_next = S_RD;
                end
            end
            S_RD:    w_state_next = r_we ? S_MERGE : S_CAP;
            S_CAP:   w_state_next = S_RESP;
            S_MERGE: w_state_next = S_RESP;
            S_WR:    w_state_next = S_RESP;
            S_RESP:  w_state_next = resp_ready ? S_IDLE : S_RESP;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_lane      <= 2'd0;
            r_widx      <= '0;
            r_wdata     <= 32'd0;
            r_resp_data <= 32'd0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we        <= req_we;
                r_funct3    <= req_funct3;
                r_lane      <= req_addr[1:0];
                r_widx      <= req_addr[AW+1:2];
                r_wdata     <= req_wdata;
                r_resp_data <= 32'd0;
                r_resp_err  <= w_err;
            end
            if (r_state == S_CAP) begin
                r_resp_data <= w_load_data;
            end
        end
    end

    // Write is gated by rst so a reset landing in MERGE/WR never corrupts memory
    assign mem_write_en   = !rst && ((r_state == S_MERGE) || (r_state == S_WR));
    assign mem_write_data = (r_state == S_MERGE) ? w_merged :
                            (r_state == S_WR)    ? r_wdata  : 32'd0;
    assign mem_addr       = (r_state == S_IDLE) ? 32'd0 : {{(32-AW){1'b0}}, r_widx};

    assign req_ready  = !rst && (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed, scoreboard-based bench for load_store_unit with a
//            behavioural one-cycle synchronous data memory.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'd0;

    logic        init_mem = 1'b1;
    logic [31:0] mem [0:4095];

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(4096), .AW(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Synchronous-read data memory; preload happens only while init_mem is high
    always @(posedge clk) begin
        if (init_mem) begin
            mem[16] <= 32'h8899AABB;
            mem[17] <= 32'h00000000;
        end else begin
            if (mem_write_en) mem[mem_addr[11:0]] <= mem_write_data;
            mem_read_data <= mem[mem_addr[11:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_wcyc,
                          input logic [31:0] exp_waddr, input logic [31:0] exp_wdata);
        int lat;
        int nwr;
        int wcyc;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic got;
        exp_t e;
        lat = 0; nwr = 0; wcyc = 0; waddr = 0; wdat = 0; got = 1'b0;
        @(negedge clk);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        sb.push_back('{data: exp_data, err: exp_err});
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (mem_write_en) begin
                nwr++; wcyc = c; waddr = mem_addr; wdat = mem_write_data;
            end
            if (resp_valid) begin
                got = 1'b1; lat = c;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_write_count"}, nwr, (exp_wcyc != 0) ? 1 : 0);
        if (exp_wcyc != 0) begin
            check({tag, "_write_cycle"}, wcyc, exp_wcyc);
            check({tag, "_write_addr"}, waddr, exp_waddr);
            check({tag, "_write_data"}, wdat, exp_wdata);
        end
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_resp_data"}, resp_data, e.data);
            check({tag, "_resp_err"}, {31'd0, resp_err}, {31'd0, e.err});
            if (!resp_ready) begin
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
                    check({tag, "_hold_data"}, resp_data, e.data);
                    check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
                end
                resp_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_resp_released"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        init_mem = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Sign/zero extension of byte and half loads from word 0x10
        do_req("lb_43",  1'b0, 3'b000, 32'h43, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0, 0, 0);
        do_req("lbu_43", 1'b0, 3'b100, 32'h43, 32'h0, 32'h00000088, 1'b0, 3, 0, 0, 0);
        do_req("lb_40",  1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFBB, 1'b0, 3, 0, 0, 0);
        do_req("lh_42",  1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8899, 1'b0, 3, 0, 0, 0);
        do_req("lhu_40", 1'b0, 3'b101, 32'h40, 32'h0, 32'h0000AABB, 1'b0, 3, 0, 0, 0);
        do_req("lw_40",  1'b0, 3'b010, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 0, 0);

        // Sub-word and whole-word stores
        do_req("sb_41",  1'b1, 3'b000, 32'h41, 32'h123456CC, 32'h0, 1'b0, 3, 2, 32'h10, 32'h8899CCBB);
        do_req("lw_40b", 1'b0, 3'b010, 32'h40, 32'h0, 32'h8899CCBB, 1'b0, 3, 0, 0, 0);
        do_req("sw_44",  1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'h11, 32'hDEADBEEF);
        do_req("sh_46",  1'b1, 3'b001, 32'h46, 32'h0000CAFE, 32'h0, 1'b0, 3, 2, 32'h11, 32'hCAFEBEEF);
        do_req("lw_44",  1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFEBEEF, 1'b0, 3, 0, 0, 0);

        // Error responses: no memory write, immediate response
        do_req("err_lw_42",   1'b0, 3'b010, 32'h42,   32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_sh_43",   1'b1, 3'b001, 32'h43,   32'h0000BEEF, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_lw_4000", 1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_f3_011",  1'b0, 3'b011, 32'h40,   32'h0, 32'h0, 1'b1, 1, 0, 0, 0);

        // Response backpressure for three cycles
        resp_ready = 1'b0;
        do_req("bp_lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h8899CCBB, 1'b0, 3, 0, 0, 0);

        // Reset landing in MERGE of an SB must suppress the write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h40; req_wdata = 32'h00000077;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmerge_mem_we", {31'd0, mem_write_en}, 32'd0);
        check("rstmerge_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmerge_req_ready_after", {31'd0, req_ready}, 32'd1);
        check("rstmerge_resp_valid_after", {31'd0, resp_valid}, 32'd0);
        check("rstmerge_mem_word", mem[16], 32'h8899CCBB);
        do_req("rstmerge_lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h8899CCBB, 1'b0, 3, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
